// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch condition evaluation plus a PC-indexed 2-bit saturating-counter
//   pattern history table (PHT). Fetch reads a prediction combinationally;
//   EX resolves the branch against the NVZ flags, trains the PHT, flags
//   mispredicts and keeps saturating statistics counters.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flag_we/mask/in     masked NVZ flag write ({N,V,Z})
//   o_flags_out           registered NVZ flags
//   i_fetch_pc            fetch PC; o_pred_taken is PHT[pc[IDX_W:1]][1]
//   i_resolve_*           branch in EX: valid, pc, condition, fetch prediction
//   i_flush               squashes the branch in EX
//   o_actual_taken        registered condition result of last accepted resolve
//   o_mispredict          registered one-cycle mispredict pulse
//   o_branch_count        saturating count of accepted resolves
//   o_mispredict_count    saturating count of mispredicts
module branch_predict_unit #(
  parameter int unsigned PC_W        = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FLAG_BYPASS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flag_we,
  input  logic [2:0]       i_flag_mask,
  input  logic [2:0]       i_flag_in,
  output logic [2:0]       o_flags_out,
  input  logic [PC_W-1:0]  i_fetch_pc,
  output logic             o_pred_taken,
  input  logic             i_resolve_valid,
  input  logic [PC_W-1:0]  i_resolve_pc,
  input  logic [2:0]       i_resolve_cond,
  input  logic             i_resolve_pred,
  input  logic             i_flush,
  output logic             o_actual_taken,
  output logic             o_mispredict,
  output logic [CNT_W-1:0] o_branch_count,
  output logic [CNT_W-1:0] o_mispredict_count
);

  localparam int unsigned Entries = 1 << IDX_W;

  logic [2:0]       r_flags;
  logic [1:0]       r_pht [Entries];
  logic             r_actual_taken;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic [2:0]       w_wmask;
  logic [2:0]       w_flags_next;
  logic [2:0]       w_eff;
  logic             w_n, w_v, w_z;
  logic             w_taken;
  logic             w_accept;
  logic             w_mis;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic [1:0]       w_ctr;
  logic [1:0]       w_ctr_next;

  // Masked merge of the flag write; also the bypass source for resolve.
  assign w_wmask      = {3{i_flag_we}} & i_flag_mask;
  assign w_flags_next = (w_wmask & i_flag_in) | (~w_wmask & r_flags);

  assign w_eff = ((FLAG_BYPASS != 0) && i_flag_we) ? w_flags_next : r_flags;
  assign w_n   = w_eff[2];
  assign w_v   = w_eff[1];
  assign w_z   = w_eff[0];

  always_comb begin
    w_taken = 1'b0;
    unique case (i_resolve_cond)
      3'b000:  w_taken = ~w_z;
      3'b001:  w_taken = w_z;
      3'b010:  w_taken = ~w_n & ~w_z;
      3'b011:  w_taken = w_n;
      3'b100:  w_taken = w_z | (~w_n & ~w_z);
      3'b101:  w_taken = w_n | w_z;
      3'b110:  w_taken = w_v;
      default: w_taken = 1'b1;
    endcase
  end

  assign w_accept    = i_resolve_valid & ~i_flush;
  assign w_mis       = w_taken != i_resolve_pred;
  assign w_fetch_idx = i_fetch_pc[IDX_W:1];
  assign w_res_idx   = i_resolve_pc[IDX_W:1];
  assign w_ctr       = r_pht[w_res_idx];

  // Saturating 2-bit counter step.
  always_comb begin
    w_ctr_next = w_ctr;
    if (w_taken) begin
      if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'b01;
    end else begin
      if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags            <= 3'b000;
      r_actual_taken     <= 1'b0;
      r_mispredict       <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
      for (int i = 0; i < Entries; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else begin
      r_flags <= w_flags_next;
      if (w_accept) begin
        r_actual_taken   <= w_taken;
        r_mispredict     <= w_mis;
        r_pht[w_res_idx] <= w_ctr_next;
        if (r_branch_count != '1) r_branch_count <= r_branch_count + CNT_W'(1);
        if (w_mis && (r_mispredict_count != '1)) begin
          r_mispredict_count <= r_mispredict_count + CNT_W'(1);
        end
      end else begin
        r_mispredict <= 1'b0;
      end
    end
  end

  // Read of the pre-update array: no write-to-read bypass on index conflict.
  assign o_pred_taken       = r_pht[w_fetch_idx][1];
  assign o_flags_out        = r_flags;
  assign o_actual_taken     = r_actual_taken;
  assign o_mispredict       = r_mispredict;
  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;

endmodule
